// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter_pkg
// Brief   : Shared constants, types and helpers for the writeback arbiter.
// Revision: 1.0
// ============================================================================
package regfile_write_arbiter_pkg;

  localparam int         NUM_CH  = 3;
  localparam logic [1:0] CH_ALU  = 2'd0;
  localparam logic [1:0] CH_BASE = 2'd1;
  localparam logic [1:0] CH_LOAD = 2'd2;
  localparam logic [3:0] REG_PC  = 4'd15;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == CH_LOAD) ? CH_ALU : ch + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter_if
// Brief   : Writeback request, claim and register-file write bundle.
// Revision: 1.0
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
);
  localparam int AW = $clog2(NUM_REGS);

  logic [2:0]             req_valid;
  logic [2:0][AW-1:0]     req_addr;
  logic [2:0][DATA_W-1:0] req_data;
  logic [2:0]             req_ready;
  logic                   claim_valid;
  logic [AW-1:0]          claim_reg;
  logic                   w_en;
  logic [AW-1:0]          w_addr;
  logic [DATA_W-1:0]      w_data;
  logic [NUM_REGS-1:0]    pending;
  logic                   pc_redirect;
  logic                   busy;

  modport master (
    output req_valid, req_addr, req_data, claim_valid, claim_reg,
    input  req_ready, w_en, w_addr, w_data, pending, pc_redirect, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, claim_valid, claim_reg,
    output req_ready, w_en, w_addr, w_data, pending, pc_redirect, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_age_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_age_arbiter
// Brief   : 3-way round-robin over an eligibility mask, one-hot grant.
// Revision: 1.0
// ============================================================================
module rr_age_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] eligible,
  output logic [NUM_CH-1:0] grant
);

  logic [1:0] r_ptr;
  logic [1:0] w_idx;
  logic       w_found;

  // Walk from the pointer; w_idx is left on the granted channel.
  always_comb begin
    grant   = '0;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found) begin
        if (eligible[w_idx]) begin
          grant[w_idx] = 1'b1;
          w_found      = 1'b1;
        end else begin
          w_idx = next_ch(w_idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= CH_ALU;
    end else if (w_found) begin
      r_ptr <= next_ch(w_idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Shares the register-file write port among ALU, base and load.
// Revision: 1.0
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int PC_REG   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int            AW   = $clog2(NUM_REGS);
  localparam logic [AW-1:0] C_PC = AW'(PC_REG);

  logic [NUM_CH-1:0]             r_occ;
  logic [NUM_CH-1:0][AW-1:0]     r_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] r_data;
  logic [NUM_CH-1:0][1:0]        r_age;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_accept;
  logic [AW-1:0]     w_gaddr;
  logic [DATA_W-1:0] w_gdata;

  logic                r_w_en;
  logic [AW-1:0]       r_w_addr;
  logic [DATA_W-1:0]   r_w_data;
  logic                r_pc_redirect;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;

  // A slot is blocked by any same-address slot that is older, or equally old
  // on a higher channel (load beats base beats ALU).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = r_occ[i];
      for (int j = 0; j < NUM_CH; j++) begin
        if (j != i && r_occ[j] && r_addr[j] == r_addr[i] &&
            (r_age[j] > r_age[i] || (r_age[j] == r_age[i] && j > i))) begin
          w_elig[i] = 1'b0;
        end
      end
    end
  end

  rr_age_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (w_elig),
    .grant    (w_grant)
  );

  always_comb begin
    w_gaddr = '0;
    w_gdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_gaddr = r_addr[i];
        w_gdata = r_data[i];
      end
    end
  end

  assign bus.req_ready = ~r_occ | w_grant;
  assign w_accept      = bus.req_valid & bus.req_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_occ[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_age[i]  <= 2'd0;
      end else if (w_accept[i]) begin
        r_occ[i]  <= 1'b1;
        r_addr[i] <= bus.req_addr[i];
        r_data[i] <= bus.req_data[i];
        r_age[i]  <= 2'd0;
      end else if (w_grant[i]) begin
        r_occ[i]  <= 1'b0;
      end else if (r_occ[i] && r_age[i] != 2'd3) begin
        r_age[i]  <= r_age[i] + 2'd1;
      end
    end
  end

  // A claim landing on the same edge as the clearing write is younger, so it wins.
  assign w_set = bus.claim_valid ? (NUM_REGS'(1) << bus.claim_reg) : '0;
  assign w_clr = r_w_en          ? (NUM_REGS'(1) << r_w_addr)      : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_en        <= 1'b0;
      r_w_addr      <= '0;
      r_w_data      <= '0;
      r_pc_redirect <= 1'b0;
      r_pending     <= '0;
    end else begin
      r_w_en        <= |w_grant;
      r_pc_redirect <= (|w_grant) && (w_gaddr == C_PC);
      if (|w_grant) begin
        r_w_addr <= w_gaddr;
        r_w_data <= w_gdata;
      end
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign bus.w_en        = r_w_en;
  assign bus.w_addr      = r_w_addr;
  assign bus.w_data      = r_w_data;
  assign bus.pc_redirect = r_pc_redirect;
  assign bus.pending     = r_pending;
  assign bus.busy        = |r_occ;

endmodule
`default_nettype wire
